data_scale_pipe: RTL and testbench

- Parametrised fixed-point input scaler: converts raw ADC samples to signed fixed-point for the Goertzel filter datapath.
- Generalises the fixed 8-bit × 13/256 scaler with:
  - configurable widths;
  - runtime-loadable coefficient and DC offset;
  - signed or unsigned input mode;
  - round and saturate on the output;
  - valid/ready flow control with a 2-stage pipeline.
- Sits between the sample capture logic and the Goertzel core.

---
 rtl/gs_scale_pkg.sv | 48 ++++
 rtl/data_scale_pipe_if.sv | 35 +++
 rtl/scale_mul_rnd.sv | 72 +++++++
 rtl/data_scale_pipe.sv | 135 +++++++++++++
 tb/tb_data_scale_pipe.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gs_scale_pkg.sv
// Shared constants and helpers for the input scaler and the Goertzel datapath.
// Holds default widths, the reset coefficient (13/256 in Q8.24) and the
// round-then-saturate helper used by the stage-2 multiplier.
package gs_scale_pkg;

  localparam int unsigned DIN_W_DEF     = 8;
  localparam int unsigned COEF_W_DEF    = 32;
  localparam int unsigned COEF_FRAC_DEF = 24;
  localparam int unsigned OUT_W_DEF     = 32;
  localparam int unsigned OUT_FRAC_DEF  = 24;
  localparam logic [31:0] COEF_RST_DEF  = 32'h000D_0000;

  // Wide enough to hold any product this block family produces plus rounding headroom.
  localparam int unsigned WIDE_W = 128;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t val;
  } sat_res_t;

  // Round half up by sh bits (no rounding when sh == 0), then clip to signed out_w.
  function automatic sat_res_t sat_round(input wide_t product, input int unsigned sh,
                                         input int unsigned out_w);
    wide_t    rnd;
    wide_t    max_v;
    wide_t    min_v;
    sat_res_t res;
    rnd = product;
    if (sh > 0) begin
      rnd = (product + (wide_t'(1) <<< (sh - 1))) >>> sh;
    end
    max_v   = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    min_v   = -(wide_t'(1) <<< (out_w - 1));
    res.sat = 1'b0;
    res.val = rnd;
    if (rnd > max_v) begin
      res.val = max_v;
      res.sat = 1'b1;
    end else if (rnd < min_v) begin
      res.val = min_v;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/data_scale_pipe_if.sv
// Stream and configuration bundle for data_scale_pipe.
// master: sample source / config writer / downstream sink (drives inputs).
// slave : the scaler (drives in_ready, out_valid, data_o, sat_o).
interface data_scale_pipe_if
  import gs_scale_pkg::*;
#(
  parameter int unsigned DIN_W  = DIN_W_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) ();

  logic                    mode_signed;
  logic [COEF_W-1:0]       coef_i;
  logic signed [DIN_W:0]   offset_i;
  logic                    cfg_load;
  logic                    in_valid;
  logic                    in_ready;
  logic [DIN_W-1:0]        data_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] data_o;
  logic                    sat_o;
  logic                    sat_clr;

  modport master (
    output mode_signed, coef_i, offset_i, cfg_load, in_valid, data_i, out_ready, sat_clr,
    input  in_ready, out_valid, data_o, sat_o
  );

  modport slave (
    input  mode_signed, coef_i, offset_i, cfg_load, in_valid, data_i, out_ready, sat_clr,
    output in_ready, out_valid, data_o, sat_o
  );

endinterface

// File: rtl/scale_mul_rnd.sv
// Stage 2: registered signed x unsigned multiply, round and saturate.
// Ports: clk, rstn (async active-low), en_i (pipeline advance), valid_i/x_i/coef_i
// (stage-1 payload), valid_o/data_o (registered result), sat_c (clip strobe,
// combinational, high when a clipped result is loaded on the coming edge).
module scale_mul_rnd
  import gs_scale_pkg::*;
#(
  parameter int unsigned X_W       = DIN_W_DEF + 2,
  parameter int unsigned COEF_W    = COEF_W_DEF,
  parameter int unsigned COEF_FRAC = COEF_FRAC_DEF,
  parameter int unsigned OUT_W     = OUT_W_DEF,
  parameter int unsigned OUT_FRAC  = OUT_FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic signed [X_W-1:0]   x_i,
  input  logic [COEF_W-1:0]       coef_i,
  output logic                    valid_o,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    sat_c
);

  // Extra bit keeps the unsigned coefficient positive inside a signed product.
  localparam int unsigned PROD_W = X_W + COEF_W + 1;
  localparam int unsigned SH     = COEF_FRAC - OUT_FRAC;

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] coef_ext;
  logic signed [PROD_W-1:0] prod;
  sat_res_t                 res;

  logic                     valid_q, valid_d;
  logic signed [OUT_W-1:0]  data_q,  data_d;

  // Full-width product, then round/saturate.
  always_comb begin
    x_ext    = PROD_W'(x_i);
    coef_ext = $signed(PROD_W'(coef_i));
    prod     = x_ext * coef_ext;
    res      = sat_round(wide_t'(prod), SH, OUT_W);
  end

  // Advance only when enabled; data_o keeps its last value across bubbles.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sat_c   = 1'b0;
    if (en_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = OUT_W'(res.val);
        sat_c  = res.sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/data_scale_pipe.sv
// Two-stage fixed-point input scaler feeding the Goertzel core.
// Stage 1 extends the raw sample and removes the DC offset; stage 2
// (scale_mul_rnd) multiplies by the coefficient, rounds and saturates.
// Ports: clk, rstn (async active-low), bus (data_scale_pipe_if.slave):
// sample stream in (in_valid/in_ready/data_i/mode_signed), result stream out
// (out_valid/out_ready/data_o), config load (cfg_load/coef_i/offset_i),
// sticky saturation flag (sat_o/sat_clr).
module data_scale_pipe
  import gs_scale_pkg::*;
#(
  parameter int unsigned       DIN_W     = DIN_W_DEF,
  parameter int unsigned       COEF_W    = COEF_W_DEF,
  parameter int unsigned       COEF_FRAC = COEF_FRAC_DEF,
  parameter int unsigned       OUT_W     = OUT_W_DEF,
  parameter int unsigned       OUT_FRAC  = OUT_FRAC_DEF,
  parameter logic [COEF_W-1:0] COEF_RST  = COEF_W'(COEF_RST_DEF)
) (
  input logic              clk,
  input logic              rstn,
  data_scale_pipe_if.slave bus
);

  // Offset-corrected sample range needs two bits beyond the raw width.
  localparam int unsigned X_W = DIN_W + 2;

  logic                    en_c;
  logic                    accept_c;
  logic                    upd_c;
  logic                    s2_valid;
  logic signed [OUT_W-1:0] s2_data;
  logic                    sat_set_c;

  logic [COEF_W-1:0]       coef_sh_q,  coef_sh_d;
  logic signed [DIN_W:0]   off_sh_q,   off_sh_d;
  logic [COEF_W-1:0]       coef_act_q, coef_act_d;
  logic signed [DIN_W:0]   off_act_q,  off_act_d;
  logic                    s1_valid_q, s1_valid_d;
  logic signed [X_W-1:0]   x_q,        x_d;
  logic [COEF_W-1:0]       coef_s1_q,  coef_s1_d;
  logic                    sat_q,      sat_d;
  logic signed [X_W-1:0]   din_ext;
  logic signed [X_W-1:0]   off_ext;

  // Handshake: advance whenever the output register is free or being drained.
  always_comb begin
    en_c     = !s2_valid || bus.out_ready;
    accept_c = bus.in_valid && en_c;
    upd_c    = accept_c || (!s1_valid_q && !s2_valid);
  end

  // Config shadow/active registers and stage 1.
  // The accepting sample sees the freshly promoted values; the coefficient
  // travels with the sample so a later promotion cannot affect it in stage 2.
  always_comb begin
    coef_sh_d  = coef_sh_q;
    off_sh_d   = off_sh_q;
    coef_act_d = coef_act_q;
    off_act_d  = off_act_q;
    s1_valid_d = s1_valid_q;
    x_d        = x_q;
    coef_s1_d  = coef_s1_q;
    din_ext    = bus.mode_signed ? X_W'($signed(bus.data_i)) : X_W'(bus.data_i);

    if (bus.cfg_load) begin
      coef_sh_d = bus.coef_i;
      off_sh_d  = bus.offset_i;
    end
    if (upd_c) begin
      coef_act_d = coef_sh_q;
      off_act_d  = off_sh_q;
    end

    off_ext = X_W'(off_act_d);
    if (en_c) begin
      s1_valid_d = accept_c;
      if (accept_c) begin
        x_d       = din_ext - off_ext;
        coef_s1_d = coef_act_d;
      end
    end
  end

  // Sticky saturation flag; a new clip beats a simultaneous clear.
  always_comb begin
    sat_d = sat_q;
    if (bus.sat_clr) sat_d = 1'b0;
    if (sat_set_c)   sat_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_sh_q  <= COEF_RST;
      off_sh_q   <= '0;
      coef_act_q <= COEF_RST;
      off_act_q  <= '0;
      s1_valid_q <= 1'b0;
      x_q        <= '0;
      coef_s1_q  <= COEF_RST;
      sat_q      <= 1'b0;
    end else begin
      coef_sh_q  <= coef_sh_d;
      off_sh_q   <= off_sh_d;
      coef_act_q <= coef_act_d;
      off_act_q  <= off_act_d;
      s1_valid_q <= s1_valid_d;
      x_q        <= x_d;
      coef_s1_q  <= coef_s1_d;
      sat_q      <= sat_d;
    end
  end

  scale_mul_rnd #(
    .X_W      (X_W),
    .COEF_W   (COEF_W),
    .COEF_FRAC(COEF_FRAC),
    .OUT_W    (OUT_W),
    .OUT_FRAC (OUT_FRAC)
  ) u_stage2 (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (en_c),
    .valid_i(s1_valid_q),
    .x_i    (x_q),
    .coef_i (coef_s1_q),
    .valid_o(s2_valid),
    .data_o (s2_data),
    .sat_c  (sat_set_c)
  );

  assign bus.in_ready  = en_c;
  assign bus.out_valid = s2_valid;
  assign bus.data_o    = s2_data;
  assign bus.sat_o     = sat_q;

endmodule

// File: tb/tb_data_scale_pipe.sv
// Self-checking bench for data_scale_pipe: directed vector table, corner-case
// sequences and handshake streams checked against an arithmetic reference model.
module tb_data_scale_pipe;
  import gs_scale_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  data_scale_pipe_if bus ();

  data_scale_pipe dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model of the configuration a newly accepted sample will use.
  logic [31:0]       m_coef;
  logic signed [8:0] m_off;
  bit                m_sat;

  typedef struct {
    bit                load;
    logic [31:0]       coef;
    logic signed [8:0] off;
    bit                mode;
    logic [7:0]        data;
    logic [31:0]       exp;
    bit                sat_ev;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // y = sat(round((ext(d) - off) * coef)) computed with plain integer arithmetic.
  function automatic void ref_model(input bit mode, input logic [31:0] coef,
                                    input logic signed [8:0] off, input logic [7:0] d,
                                    output logic [31:0] y, output bit sat);
    longint xv, p;
    int     sh;
    sh  = int'(COEF_FRAC_DEF) - int'(OUT_FRAC_DEF);
    xv  = mode ? longint'($signed(d)) : longint'(d);
    xv  = xv - longint'(off);
    p   = xv * longint'(coef);
    if (sh > 0) p = (p + (longint'(1) <<< (sh - 1))) >>> sh;
    sat = 1'b0;
    if (p > 64'sd2147483647) begin
      p = 64'sd2147483647; sat = 1'b1;
    end else if (p < -64'sd2147483648) begin
      p = -64'sd2147483648; sat = 1'b1;
    end
    y = p[31:0];
  endfunction

  task automatic do_load(input logic [31:0] coef, input logic signed [8:0] off);
    bus.coef_i   = coef;
    bus.offset_i = off;
    bus.cfg_load = 1'b1;
    @(posedge clk); #1;
    bus.cfg_load = 1'b0;
    m_coef = coef;
    m_off  = off;
  endtask

  // One isolated sample: checks acceptance, exact 2-edge latency and result.
  task automatic send_check(input string name, input bit mode, input logic [7:0] d,
                            input logic [31:0] exp, input bit exp_sat);
    bus.in_valid    = 1'b1;
    bus.data_i      = d;
    bus.mode_signed = mode;
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({name, "_lat_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_data"}, bus.data_o, exp);
    check({name, "_sat"}, 32'(bus.sat_o), 32'(exp_sat));
  endtask

  // kind 0: out_ready 1-0-0-1 pattern, kind 1: random ready/valid, kind 2: always ready.
  task automatic run_stream(input string name, input int n, input int kind);
    logic [31:0] expq[$];
    int          sent, got, cyc;
    bit          stall_prev, acc, m, s;
    logic [31:0] held, y;
    logic [7:0]  d;
    sent = 0; got = 0; cyc = 0; stall_prev = 0; held = '0; m = 0; d = '0;
    bus.in_valid = 1'b0;
    while (got < n && cyc < 4000) begin
      case (kind)
        0:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
      if (!bus.in_valid && sent < n && (kind != 1 || $urandom_range(0, 3) != 0)) begin
        d = 8'($urandom);
        m = 1'($urandom);
        bus.data_i      = d;
        bus.mode_signed = m;
        bus.in_valid    = 1'b1;
      end
      @(negedge clk);
      if (stall_prev) begin
        check({name, "_stall_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_stall_data"}, bus.data_o, held);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus.data_o;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s_extra: got output %h, expected none", name, bus.data_o);
        end else begin
          check({name, "_data"}, bus.data_o, expq.pop_front());
        end
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        ref_model(m, m_coef, m_off, d, y, s);
        expq.push_back(y);
        sent++;
      end
      @(posedge clk); #1;
      if (acc) bus.in_valid = 1'b0;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check({name, "_count"}, 32'(got), 32'(n));
    check({name, "_leftover"}, 32'(expq.size()), 32'd0);
    if (kind == 2) check({name, "_throughput"}, 32'(cyc <= n + 3), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] y;
    bit          s;

    bus.mode_signed = 1'b0;
    bus.coef_i      = '0;
    bus.offset_i    = '0;
    bus.cfg_load    = 1'b0;
    bus.in_valid    = 1'b0;
    bus.data_i      = '0;
    bus.out_ready   = 1'b1;
    bus.sat_clr     = 1'b0;
    m_coef = 32'h000D_0000;
    m_off  = '0;
    m_sat  = 1'b0;

    // Directed vectors, then random ones whose expectations come from the model.
    vt[0] = '{0, 32'h0, 9'sd0, 0, 8'hFF, 32'h0CF3_0000, 0};
    vt[1] = '{0, 32'h0, 9'sd0, 0, 8'h00, 32'h0000_0000, 0};
    vt[2] = '{0, 32'h0, 9'sd0, 1, 8'h80, 32'hF980_0000, 0};
    vt[3] = '{1, 32'h000D_0000, 9'sd128, 0, 8'h00, 32'hF980_0000, 0};
    vt[4] = '{0, 32'h0, 9'sd0, 0, 8'h80, 32'h0000_0000, 0};
    vt[5] = '{1, 32'hFFFF_FFFF, 9'sd0, 0, 8'hFF, 32'h7FFF_FFFF, 1};
    for (int i = 6; i < 12; i++) begin
      vt[i].load = 1;
      vt[i].coef = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 32'h00FF_FFFF))
                                               : 32'($urandom);
      vt[i].off  = 9'($urandom);
      vt[i].mode = 1'($urandom);
      vt[i].data = 8'($urandom);
      ref_model(vt[i].mode, vt[i].coef, vt[i].off, vt[i].data, y, s);
      vt[i].exp    = y;
      vt[i].sat_ev = s;
    end

    // Reset state.
    rstn = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data_o", bus.data_o, 32'd0);
    check("rst_sat_o", 32'(bus.sat_o), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      if (vt[i].load) do_load(vt[i].coef, vt[i].off);
      m_sat = m_sat | vt[i].sat_ev;
      send_check($sformatf("vec%0d", i), vt[i].mode, vt[i].data, vt[i].exp, m_sat);
    end

    // Sticky clear.
    bus.sat_clr = 1'b1;
    @(posedge clk); #1;
    bus.sat_clr = 1'b0;
    check("sat_clr", 32'(bus.sat_o), 32'd0);

    // Clear coinciding with a new clip: set wins.
    do_load(32'hFFFF_FFFF, 9'sd0);
    bus.in_valid = 1'b1; bus.data_i = 8'hFF; bus.mode_signed = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.sat_clr  = 1'b1;
    @(posedge clk); #1;
    bus.sat_clr  = 1'b0;
    check("sat_set_wins", 32'(bus.sat_o), 32'd1);
    check("sat_set_data", bus.data_o, 32'h7FFF_FFFF);
    bus.sat_clr = 1'b1;
    @(posedge clk); #1;
    bus.sat_clr = 1'b0;
    check("sat_clr2", 32'(bus.sat_o), 32'd0);

    // cfg_load in the accepting cycle applies to the following sample only.
    do_load(32'h000D_0000, 9'sd0);
    bus.in_valid = 1'b1; bus.data_i = 8'hFF; bus.mode_signed = 1'b0;
    bus.coef_i   = 32'h001A_0000; bus.offset_i = 9'sd0; bus.cfg_load = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.cfg_load = 1'b0;
    m_coef = 32'h001A_0000;
    @(posedge clk); #1;
    check("cfg_same_cycle_old", bus.data_o, 32'h0CF3_0000);
    send_check("cfg_same_cycle_new", 1'b0, 8'hFF, 32'h19E6_0000, 1'b0);

    // Backpressure streams.
    do_load(32'h000D_0000, 9'sd0);
    run_stream("bp_pattern", 8, 0);
    do_load(32'($urandom_range(0, 32'h01FF_FFFF)), 9'($urandom));
    run_stream("bp_random", 200, 1);
    run_stream("full_rate", 20, 2);

    // Reset with two samples in flight.
    do_load(32'h0010_0000, 9'sd5);
    bus.in_valid = 1'b1; bus.data_i = 8'hFF; bus.mode_signed = 1'b0;
    @(posedge clk); #1;
    bus.data_i = 8'h01;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("inflight_valid_pre", 32'(bus.out_valid), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_data_o", bus.data_o, 32'd0);
    check("midrst_sat_o", 32'(bus.sat_o), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_coef = 32'h000D_0000;
    m_off  = '0;
    @(posedge clk); #1;
    check("postrst_idle", 32'(bus.out_valid), 32'd0);
    send_check("postrst_first", 1'b0, 8'hFF, 32'h0CF3_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
